// File: rtl/rpc_cmd_engine.sv
// RPC host-link command engine: command decode, TDC FIFO and half-duplex burst readout.
// Optional feature macro RPC_BURST_HEADER_EN prefixes each DUMP burst with a {4'hA, W} header.
module rpc_cmd_engine #(
   parameter int DATA_W     = 16,
   parameter int NUM_CH     = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int CMD_W      = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CMD_W-1:0]             cmd,
   input  logic [DATA_W-1:0]            bus_in,
   input  logic                         bus_in_valid,
   output logic [DATA_W-1:0]            bus_out,
   output logic                         bus_out_valid,
   output logic                         bus_oe,
   input  logic [DATA_W-1:0]            tdc_data,
   input  logic                         tdc_valid,
   output logic                         run,
   output logic [NUM_CH*DATA_W-1:0]     ch_delay,
   output logic [DATA_W-1:0]            gate_size,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
`ifdef RPC_BURST_HEADER_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   localparam logic [CMD_W-1:0] CMD_SEL_CH    = CMD_W'(0);
   localparam logic [CMD_W-1:0] CMD_SET_DELAY = CMD_W'(1);
   localparam logic [CMD_W-1:0] CMD_SET_GATE  = CMD_W'(2);
   localparam logic [CMD_W-1:0] CMD_DUMP      = CMD_W'(3);
   localparam logic [CMD_W-1:0] CMD_RUN_START = CMD_W'(4);
   localparam logic [CMD_W-1:0] CMD_RUN_STOP  = CMD_W'(5);
   localparam logic [CMD_W-1:0] CMD_STATUS    = CMD_W'(6);
   localparam logic [CMD_W-1:0] CMD_CLEAR     = CMD_W'(7);

   typedef enum logic [1:0] {S_IDLE, S_TURN, S_SEND, S_RELEASE} state_t;
   state_t state_reg, state_next;

   logic [3:0]        ch_sel_reg;
   logic              run_reg;
   logic              overflow_reg;
   logic [DATA_W-1:0] gate_reg;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]     count_reg;

   logic [CW-1:0]     send_left_reg;
   logic              resp_pending_reg;
   logic [DATA_W-1:0] resp_word_reg;

   logic              cmd_exec;
   logic              do_clear, do_dump, do_status;
   logic              full, push_req, push, pop;
   logic [CW-1:0]     dump_w;
   logic [DATA_W-1:0] status_word;

   assign cmd_exec  = bus_in_valid && (state_reg == S_IDLE);
   assign do_clear  = cmd_exec && (cmd == CMD_CLEAR);
   assign do_dump   = cmd_exec && (cmd == CMD_DUMP);
   assign do_status = cmd_exec && (cmd == CMD_STATUS);

   assign full      = (count_reg == CW'(FIFO_DEPTH));
   assign push_req  = tdc_valid && run_reg;
   assign push      = push_req && !do_clear && (!full || pop);

   // Burst length snapshot: N=0 or N beyond the fill level means "everything buffered now"
   always_comb begin
      dump_w = count_reg;
      if ((bus_in != '0) && (bus_in < DATA_W'(count_reg)))
         dump_w = CW'(bus_in);
   end

   always_comb begin
      status_word           = '0;
      status_word[DATA_W-1] = overflow_reg;
      status_word[DATA_W-2] = run_reg;
      status_word[CW-1:0]   = count_reg;
   end

   // Configuration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_sel_reg <= '0;
         run_reg    <= 1'b0;
         gate_reg   <= '0;
      end else if (cmd_exec) begin
         case (cmd)
            CMD_SEL_CH:    ch_sel_reg <= bus_in[3:0];
            CMD_SET_GATE:  gate_reg   <= bus_in;
            CMD_RUN_START: run_reg    <= 1'b1;
            CMD_RUN_STOP:  run_reg    <= 1'b0;
            default:       ;
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] delay_reg;
      always_ff @(posedge clk) begin
         if (rst)
            delay_reg <= '0;
         else if (cmd_exec && (cmd == CMD_SET_DELAY) && (ch_sel_reg == 4'(gi)))
            delay_reg <= bus_in;
      end
      assign ch_delay[gi*DATA_W +: DATA_W] = delay_reg;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= tdc_data;
   end

   always_ff @(posedge clk) begin
      if (rst || do_clear) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(push) - CW'(pop);
         if (push_req && full && !pop)
            overflow_reg <= 1'b1;
      end
   end

   // Burst bookkeeping: send_left counts SEND cycles, resp_word holds header/status word
   always_ff @(posedge clk) begin
      if (rst) begin
         send_left_reg    <= '0;
         resp_pending_reg <= 1'b0;
         resp_word_reg    <= '0;
      end else if (do_status) begin
         send_left_reg    <= CW'(1);
         resp_pending_reg <= 1'b1;
         resp_word_reg    <= status_word;
      end else if (do_dump) begin
         send_left_reg    <= dump_w + CW'(HDR_EN);
         resp_pending_reg <= HDR_EN;
         resp_word_reg    <= {4'hA, (DATA_W-4)'(dump_w)};
      end else if (state_reg == S_SEND) begin
         send_left_reg    <= send_left_reg - 1'b1;
         resp_pending_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (do_dump || do_status) state_next = S_TURN;
         S_TURN:    state_next = (send_left_reg == '0) ? S_RELEASE : S_SEND;
         S_SEND:    if (send_left_reg == CW'(1)) state_next = S_RELEASE;
         S_RELEASE: state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Outputs are gated by rst so the bus is released within the reset cycle itself
   always_comb begin
      bus_oe        = 1'b0;
      bus_out_valid = 1'b0;
      bus_out       = '0;
      pop           = 1'b0;
      if (!rst) begin
         case (state_reg)
            S_TURN, S_RELEASE: bus_oe = 1'b1;
            S_SEND: begin
               bus_oe        = 1'b1;
               bus_out_valid = 1'b1;
               bus_out       = resp_pending_reg ? resp_word_reg : mem[rd_ptr_reg];
               pop           = !resp_pending_reg;
            end
            default: ;
         endcase
      end
   end

   assign run        = run_reg;
   assign gate_size  = gate_reg;
   assign fifo_count = count_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_rpc_cmd_engine.sv
// Randomized self-checking bench for rpc_cmd_engine against a queue-based transaction model.
// Honours RPC_BURST_HEADER_EN when predicting DUMP bursts.
module tb_rpc_cmd_engine;
   localparam int DATA_W     = 16;
   localparam int NUM_CH     = 2;
   localparam int FIFO_DEPTH = 16;
   localparam int CMD_W      = 3;
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [CMD_W-1:0]          cmd;
   logic [DATA_W-1:0]         bus_in;
   logic                      bus_in_valid;
   logic [DATA_W-1:0]         bus_out;
   logic                      bus_out_valid;
   logic                      bus_oe;
   logic [DATA_W-1:0]         tdc_data;
   logic                      tdc_valid;
   logic                      run;
   logic [NUM_CH*DATA_W-1:0]  ch_delay;
   logic [DATA_W-1:0]         gate_size;
   logic [CW-1:0]             fifo_count;
   logic                      overflow;

   rpc_cmd_engine #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .CMD_W(CMD_W)
   ) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .bus_in(bus_in), .bus_in_valid(bus_in_valid),
      .bus_out(bus_out), .bus_out_valid(bus_out_valid), .bus_oe(bus_oe),
      .tdc_data(tdc_data), .tdc_valid(tdc_valid), .run(run), .ch_delay(ch_delay),
      .gate_size(gate_size), .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [DATA_W-1:0] q[$];
   bit                m_run;
   bit                m_ovf;
   logic [DATA_W-1:0] m_delay [NUM_CH];
   logic [DATA_W-1:0] m_gate;
   int                m_sel;
   logic [DATA_W-1:0] last_seen;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_model();
      q.delete();
      m_run  = 0;
      m_ovf  = 0;
      m_gate = '0;
      m_sel  = 0;
      for (int i = 0; i < NUM_CH; i++) m_delay[i] = '0;
   endtask

   function automatic logic [DATA_W-1:0] status_word();
      logic [DATA_W-1:0] sw;
      sw           = '0;
      sw[DATA_W-1] = m_ovf;
      sw[DATA_W-2] = m_run;
      sw[CW-1:0]   = CW'(q.size());
      return sw;
   endfunction

   task automatic model_push(input bit v, input logic [DATA_W-1:0] d);
      if (v && m_run) begin
         if (q.size() < FIFO_DEPTH) q.push_back(d);
         else m_ovf = 1;
      end
   endtask

   task automatic check_regs(input string tag);
      logic [NUM_CH*DATA_W-1:0] e;
      for (int i = 0; i < NUM_CH; i++) e[i*DATA_W +: DATA_W] = m_delay[i];
      check({tag, "_ch_delay"}, ch_delay, e);
      check({tag, "_gate"}, gate_size, m_gate);
      check({tag, "_run"}, run, m_run);
      check({tag, "_overflow"}, overflow, m_ovf);
      check({tag, "_count"}, fifo_count, q.size());
      check({tag, "_oe"}, bus_oe, 0);
   endtask

   task automatic idle_cycle(input bit v, input logic [DATA_W-1:0] d);
      tdc_valid = v;
      tdc_data  = d;
      @(posedge clk);
      model_push(tdc_valid, tdc_data);
      #1;
      tdc_valid = 0;
   endtask

   // Non-burst command, optionally with a TDC word offered in the same cycle
   task automatic do_cmd(input int c, input logic [DATA_W-1:0] d, input bit pv,
                         input logic [DATA_W-1:0] pd);
      $display("cmd=%0d data=%h push=%0d", c, d, pv);
      cmd          = CMD_W'(c);
      bus_in       = d;
      bus_in_valid = 1;
      tdc_valid    = pv;
      tdc_data     = pd;
      @(posedge clk);
      model_push(tdc_valid, tdc_data);
      case (c)
         0: m_sel = int'(d[3:0]);
         1: if (m_sel < NUM_CH) m_delay[m_sel] = d;
         2: m_gate = d;
         4: m_run = 1;
         5: m_run = 0;
         7: begin q.delete(); m_ovf = 0; end
         default: ;
      endcase
      #1;
      bus_in_valid = 0;
      tdc_valid    = 0;
      check_regs("cmd");
   endtask

   task automatic drive_noise();
      tdc_valid    = 1'($urandom_range(0, 1));
      tdc_data     = DATA_W'($urandom);
      bus_in_valid = 1'($urandom_range(0, 1));
      cmd          = CMD_W'($urandom_range(0, 7));
      bus_in       = DATA_W'($urandom);
   endtask

   // DUMP (c=3) or STATUS (c=6); with disturb, random pushes and strobes hit every burst cycle
   task automatic do_burst(input int c, input logic [DATA_W-1:0] n, input bit disturb);
      logic [DATA_W-1:0] exp_q[$];
      bit                data_q[$];
      int                w;
      bit                prev_data;
      if (c == 6) begin
         exp_q.push_back(status_word());
         data_q.push_back(1'b0);
      end else begin
         w = (n == 0 || int'(n) > q.size()) ? q.size() : int'(n);
`ifdef RPC_BURST_HEADER_EN
         exp_q.push_back({4'hA, (DATA_W-4)'(w)});
         data_q.push_back(1'b0);
`endif
         for (int i = 0; i < w; i++) begin
            exp_q.push_back(q[i]);
            data_q.push_back(1'b1);
         end
      end
      $display("burst cmd=%0d n=%0d words=%0d", c, n, exp_q.size());
      cmd          = CMD_W'(c);
      bus_in       = n;
      bus_in_valid = 1;
      tdc_valid    = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
      tdc_data     = DATA_W'($urandom);
      @(posedge clk);
      model_push(tdc_valid, tdc_data);
      #1;
      bus_in_valid = 0;
      tdc_valid    = 0;
      check("turn_oe", bus_oe, 1);
      check("turn_valid", bus_out_valid, 0);
      prev_data = 0;
      for (int k = 0; k <= exp_q.size(); k++) begin
         if (disturb) drive_noise();
         @(posedge clk);
         if (prev_data) void'(q.pop_front());
         model_push(tdc_valid, tdc_data);
         #1;
         tdc_valid    = 0;
         bus_in_valid = 0;
         if (k < exp_q.size()) begin
            check("send_oe", bus_oe, 1);
            check("send_valid", bus_out_valid, 1);
            check("send_data", bus_out, exp_q[k]);
            last_seen = bus_out;
            prev_data = data_q[k];
         end else begin
            check("release_oe", bus_oe, 1);
            check("release_valid", bus_out_valid, 0);
            check("release_data", bus_out, 0);
         end
      end
      @(posedge clk);
      #1;
      check("idle_valid", bus_out_valid, 0);
      check_regs("burst");
   endtask

   initial begin
      rst          = 1;
      cmd          = '0;
      bus_in       = '0;
      bus_in_valid = 0;
      tdc_data     = '0;
      tdc_valid    = 0;
      last_seen    = '0;
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_bus_out", bus_out, 0);
      check("rst_valid", bus_out_valid, 0);
      rst = 0;
      check_regs("reset");

      // Delay register selection, including an out-of-range channel
      do_cmd(0, 16'h0001, 0, 0);
      do_cmd(1, 16'h0123, 0, 0);
      check("delay_ch1", ch_delay, 32'h0123_0000);
      do_cmd(0, 16'h0005, 0, 0);
      do_cmd(1, 16'h7777, 0, 0);
      check("delay_sel5", ch_delay, 32'h0123_0000);

      // Basic partial dump
      do_cmd(4, 0, 0, 0);
      for (int i = 0; i < 5; i++) idle_cycle(1, DATA_W'(16'hBAD0 + i));
      do_burst(3, 3, 0);
      check("dump3_last", last_seen, 16'hBAD2);
      check("dump3_count", fifo_count, 2);

      // Overflow, status word, clear
      do_cmd(7, 0, 0, 0);
      for (int i = 0; i < 17; i++) idle_cycle(1, DATA_W'($urandom));
      check("ovf_flag", overflow, 1);
      check("ovf_count", fifo_count, 16);
      do_burst(6, 0, 0);
      check("status_word", last_seen, 16'hC010);
      do_cmd(7, 0, 1, 16'h1234);
      check("clear_count", fifo_count, 0);

      // Empty dump
      do_burst(3, 0, 0);

      // Ignored strobes and pushes during a burst
      for (int i = 0; i < 6; i++) idle_cycle(1, DATA_W'($urandom));
      do_burst(3, 0, 1);

      // Randomized mix
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: begin
               for (int j = 0; j < int'($urandom_range(1, 6)); j++)
                  idle_cycle(1'($urandom_range(0, 1)), DATA_W'($urandom));
            end
            3: do_cmd(0, DATA_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), DATA_W'($urandom));
            4: do_cmd(1, DATA_W'($urandom), 1'($urandom_range(0, 1)), DATA_W'($urandom));
            5: do_cmd(2, DATA_W'($urandom), 1'($urandom_range(0, 1)), DATA_W'($urandom));
            6: do_cmd(($urandom_range(0, 3) == 0) ? 5 : 4, 0, 1'($urandom_range(0, 1)), DATA_W'($urandom));
            7: if ($urandom_range(0, 3) == 0) do_cmd(7, 0, 1, DATA_W'($urandom));
            8: do_burst(3, DATA_W'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
            default: do_burst(6, 0, 1'($urandom_range(0, 1)));
         endcase
      end

      // Reset in the second SEND cycle
      do_cmd(4, 0, 0, 0);
      for (int i = 0; i < 4; i++) idle_cycle(1, DATA_W'($urandom));
      cmd          = CMD_W'(3);
      bus_in       = '0;
      bus_in_valid = 1;
      @(posedge clk);
      #1;
      bus_in_valid = 0;
      @(posedge clk);
      #1;
      check("rst_send1_valid", bus_out_valid, 1);
      @(posedge clk);
      #1;
      check("rst_send2_valid", bus_out_valid, 1);
      rst = 1;
      #1;
      check("rst_cycle_oe", bus_oe, 0);
      check("rst_cycle_valid", bus_out_valid, 0);
      @(posedge clk);
      #1;
      check("post_rst_oe", bus_oe, 0);
      check("post_rst_valid", bus_out_valid, 0);
      check("post_rst_count", fifo_count, 0);
      check("post_rst_run", run, 0);
      rst = 0;
      reset_model();
      check_regs("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rpc_cmd_engine.md
Name: rpc_cmd_engine

Overview:
- Parametrised command/readout engine for the RPC host link; controls the TDC acquisition chain.
- Decodes host commands into per-channel delay registers, gate size and run control.
- Buffers TDC words in an internal FIFO and returns them to the host in bursts over a half-duplex data bus.
- The bus is split into in, out and output-enable signals; the top level builds the tristate pad.

Parameters:
- DATA_W, 16: bus, TDC word and config register width.
- NUM_CH, 2: number of scintillator delay channels, 1..16.
- FIFO_DEPTH, 16: TDC FIFO entries; must be a power of 2, at least 2.
- CMD_W, 3: command field width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd  in  CMD_W  command code; sampled when bus_in_valid=1.
- bus_in  in  DATA_W  host write data.
- bus_in_valid  in  1  host strobe; one cycle per command.
- bus_out  out  DATA_W  readout data.
- bus_out_valid  out  1  readout word strobe.
- bus_oe  out  1  engine drives the bus.
- tdc_data  in  DATA_W  TDC word.
- tdc_valid  in  1  TDC word strobe.
- run  out  1  acquisition enable.
- ch_delay  out  NUM_CH*DATA_W  delay registers; channel i occupies bits [i*DATA_W +: DATA_W].
- gate_size  out  DATA_W  fake-stop gate size.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current fill level.
- overflow  out  1  sticky flag: a TDC word was dropped.

Behaviour:
- Reset values:
  - run, ch_delay, gate_size, ch_sel, overflow = 0.
  - FIFO empty; fifo_count = 0.
  - bus_out = 0, bus_out_valid = 0, bus_oe = 0.
  - FSM = IDLE.
- Reset mid-burst aborts immediately and releases the bus in the reset cycle.
- Commands execute only when bus_in_valid=1 and the FSM is in IDLE. Outside IDLE, strobes are ignored and dropped, not queued.
- Command codes:
  - 0 SEL_CH: ch_sel <= bus_in[3:0].
  - 1 SET_DELAY: ch_delay[ch_sel] <= bus_in. Ignored if ch_sel >= NUM_CH.
  - 2 SET_GATE: gate_size <= bus_in.
  - 3 DUMP: burst readout; N = bus_in.
  - 4 RUN_START: run <= 1.
  - 5 RUN_STOP: run <= 0.
  - 6 STATUS: one-word response: bit DATA_W-1 = overflow, bit DATA_W-2 = run, low bits = fifo_count, all other bits 0.
  - 7 CLEAR: FIFO flushed, overflow <= 0. Any push in the same cycle is discarded.
- Register writes are visible on the outputs the cycle after the strobe.
- FIFO write side:
  - Push when tdc_valid=1 and run=1.
  - Full and no pop in the same cycle: word dropped, overflow <= 1.
  - Full with a simultaneous pop: push accepted, count unchanged.
  - tdc_valid while run=0: ignored; overflow not set.
- Readout FSM states: IDLE -> TURN -> SEND -> RELEASE -> IDLE.
  - IDLE: on DUMP, snapshot W = min(N, fifo_count), with N=0 meaning all of fifo_count. On STATUS, W=1 using the status word.
  - TURN (1 cycle): bus_oe=1, bus_out_valid=0.
  - SEND (W cycles): one word per cycle. bus_out_valid=1; bus_out = FIFO head, popped that cycle (STATUS sends the status word).
  - RELEASE (1 cycle): bus_oe=1, bus_out_valid=0, bus_out=0.
  - If W=0: TURN goes straight to RELEASE; no valid word is sent.
- Latency: strobe in cycle t -> TURN at t+1 -> first valid word at t+2 -> last word at t+1+W -> RELEASE at t+2+W -> IDLE at t+3+W.
- Words pushed during a burst are not added to W.
- run, register values and cmd changes never abort a burst.
- fifo_count wraps never: it is saturating-free and exact, range 0..FIFO_DEPTH.

Optional Feature:
- Macro: RPC_BURST_HEADER_EN.
- Defined:
  - Every DUMP burst is prefixed by one SEND cycle carrying header word {4'hA, W in the low DATA_W-4 bits}. Total SEND cycles = W+1.
  - A W=0 dump still sends the header.
  - STATUS responses get no header.
- Undefined: no header; behaviour exactly as above.

Test Plan:
- Reset, then SEL_CH 1 and SET_DELAY 0x0123 -> ch_delay[31:16]=0x0123 next cycle, ch_delay[15:0]=0. With SEL_CH 5 (NUM_CH=2), SET_DELAY -> no change.
- RUN_START, push 0xBAD0..0xBAD4, DUMP N=3 -> TURN, then 0xBAD0, 0xBAD1, 0xBAD2 valid on consecutive cycles, then RELEASE; fifo_count=2 afterwards.
- run=1, push 17 words with FIFO_DEPTH=16 -> overflow=1, fifo_count=16. STATUS -> word 0xC010. CLEAR -> overflow=0, count=0.
- DUMP N=0 on an empty FIFO -> bus_oe high for 2 cycles, no bus_out_valid. With the macro defined: one header word 0xA000.
- SET_GATE strobe during SEND -> ignored, gate_size unchanged. A tdc_valid push during SEND is not included in the burst.
- Assert rst in the second SEND cycle -> bus_oe=0, bus_out_valid=0, FIFO empty, run=0 in the next cycle.
